// File: rtl/mux_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_if
//   Bundles the requester side (four valid/lock/data lanes plus the per-lane
//   ready strobe) and the downstream valid/ready output stage of the
//   round-robin mux arbiter.
//
//   Signals
//     req_valid [3:0]    requester i has a word on req_data[i]
//     req_lock  [3:0]    requester i asks to keep the grant after this beat
//     req_data  [4*DW]   packed words, requester i at [i*DW +: DW]
//     req_ready [3:0]    beat from requester i accepted this cycle
//     sel       [1:0]    mux select (S1,S0) = granted index
//     out_valid          out_data holds a valid word
//     out_data  [DW]     registered selected word
//     out_ready          downstream accepts out_data
//     busy               arbiter is serving a grant
//
//   Modports
//     slave  : the arbiter
//     master : requesters + downstream consumer (testbench side)
// -----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
  parameter int DW = 32
);
  logic [3:0]      req_valid;
  logic [3:0]      req_lock;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic [1:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            busy;

  modport slave (
    input  req_valid, req_lock, req_data, out_ready,
    output req_ready, sel, out_valid, out_data, busy
  );

  modport master (
    output req_valid, req_lock, req_data, out_ready,
    input  req_ready, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter sharing one 4:1 DW-bit mux between four requesters.
//   The granted index drives the mux select and the selected word is
//   registered into a one-entry output stage with a valid/ready handshake.
//   A requester holding req_lock keeps the mux for up to BURST_MAX beats.
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of mux_rr_arbiter_if (request lanes, mux select,
//            output stage, busy)
//
//   Parameters
//     DW         word width per requester and output
//     BURST_MAX  max consecutive beats per grant while req_lock is held (>=1)
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_rr_arbiter_if.slave       bus
);

  // Beat counter only has to reach BURST_MAX-1.
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q,   gnt_d;
  logic [1:0]      ptr_q,   ptr_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q,  out_data_d;

  logic            free;
  logic            accept;
  logic [3:0]      req_ready;
  logic [DW-1:0]   gnt_word;

  // First valid requester after the last-served one, wrapping mod 4.
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] vld);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (vld[idx]) rr_pick = idx;
    end
  endfunction

  assign gnt_word = bus.req_data[int'(gnt_q)*DW +: DW];
  assign free     = !out_valid_q || bus.out_ready;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    req_ready   = 4'b0000;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          gnt_d   = rr_pick(ptr_q, bus.req_valid);
          burst_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!bus.req_valid[gnt_q]) begin
          // Requester withdrew before its beat was taken: release the grant.
          ptr_d   = gnt_q;
          state_d = IDLE;
        end else if (free) begin
          req_ready[gnt_q] = 1'b1;
          accept           = 1'b1;
          if (bus.req_lock[gnt_q] && (burst_q < CW'(BURST_MAX - 1))) begin
            burst_d = burst_q + CW'(1);
          end else begin
            ptr_d   = gnt_q;
            state_d = IDLE;
          end
        end
        // Valid but output stage full: hold grant and select.
      end
      default: state_d = IDLE;
    endcase

    // A drain in the same cycle as an accept just replaces the word.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_word;
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'd0;
      ptr_q       <= 2'd3;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.sel       = gnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == XFER);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DW(32)) bus  ();
  mux_rr_arbiter_if #(.DW(32)) bus1 ();

  mux_rr_arbiter #(.DW(32), .BURST_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  mux_rr_arbiter #(.DW(32), .BURST_MAX(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [31:0] v);
    bus.req_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    bus.req_valid  = '0;
    bus.req_lock   = '0;
    bus.req_data   = '0;
    bus.out_ready  = 1'b0;
    bus1.req_valid = '0;
    bus1.req_lock  = '0;
    bus1.req_data  = '0;
    bus1.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Asynchronous reset in the middle of a locked burst, then first grant.
  task automatic test_reset();
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    bus.out_ready = 1'b1;
    setd(1, 32'h0000_00AB);
    tick();
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAB) begin
      errors++;
      $display("FAIL t1_midburst got v=%0b d=%0h exp v=1 d=ab", bus.out_valid, bus.out_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sel, bus.out_valid, bus.req_ready, bus.busy} !== 8'd0) begin
      errors++;
      $display("FAIL t1_rst_ctrl got sel=%0h ov=%0b rdy=%0h busy=%0b exp all 0",
               bus.sel, bus.out_valid, bus.req_ready, bus.busy);
    end
    checks++;
    if (bus.out_data !== 32'd0) begin
      errors++;
      $display("FAIL t1_rst_data got=%0h exp=0", bus.out_data);
    end
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.sel !== 2'd0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t1_first_grant got sel=%0h busy=%0b rdy=%0h exp sel=0 busy=1 rdy=1",
               bus.sel, bus.busy, bus.req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d [4];
    d[0] = 32'h5; d[1] = 32'h16; d[2] = 32'hA; d[3] = 32'h14;
    do_reset();
    for (int i = 0; i < 4; i++) setd(i, d[i]);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.sel !== 2'(k % 4) || bus.busy !== 1'b1 || bus.req_ready !== (4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL t2_grant%0d got sel=%0h busy=%0b rdy=%0h exp sel=%0h", k,
                 bus.sel, bus.busy, bus.req_ready, k % 4);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d[k % 4] || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL t2_beat%0d got v=%0b d=%0h busy=%0b exp v=1 d=%0h busy=0", k,
                 bus.out_valid, bus.out_data, bus.busy, d[k % 4]);
      end
    end
  endtask

  task automatic test_burst();
    do_reset();
    setd(0, 32'h77);
    bus.req_valid = 4'b0011;
    bus.req_lock  = 4'b0010;
    bus.out_ready = 1'b1;
    tick();                       // grant req0 (ptr was 3)
    tick();                       // req0 beat, ptr becomes 0
    tick();                       // grant req1
    checks++;
    if (bus.sel !== 2'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_grant1 got sel=%0h busy=%0b exp sel=1 busy=1", bus.sel, bus.busy);
    end
    for (int b = 0; b < 4; b++) begin
      setd(1, 32'h100 + 32'(b));
      checks++;
      if (bus.req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL t3_rdy%0d got=%0h exp=2", b, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h100 + 32'(b) ||
          bus.busy !== (b < 3) || (b < 3 && bus.sel !== 2'd1)) begin
        errors++;
        $display("FAIL t3_beat%0d got v=%0b d=%0h busy=%0b sel=%0h exp d=%0h busy=%0b", b,
                 bus.out_valid, bus.out_data, bus.busy, bus.sel, 32'h100 + 32'(b), b < 3);
      end
    end
    tick();
    checks++;
    if (bus.sel !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_after got sel=%0h busy=%0b exp sel=0 busy=1", bus.sel, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    setd(0, 32'hD0);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    setd(0, 32'hD1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hD0 || bus.req_ready !== 4'b0000 ||
          bus.busy !== 1'b1 || bus.sel !== 2'd0) begin
        errors++;
        $display("FAIL t4_hold%0d got v=%0b d=%0h rdy=%0h busy=%0b exp v=1 d=d0 rdy=0 busy=1", c,
                 bus.out_valid, bus.out_data, bus.req_ready, bus.busy);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t4_release_rdy got=%0h exp=1", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hD1) begin
      errors++;
      $display("FAIL t4_nobubble got v=%0b d=%0h exp v=1 d=d1", bus.out_valid, bus.out_data);
    end
    bus.req_valid = 4'b0000;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hD1) begin
      errors++;
      $display("FAIL t4_drain got v=%0b d=%0h exp v=0 d=d1", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    setd(3, 32'h33);
    bus.req_valid = 4'b1000;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.sel !== 2'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_grant3 got sel=%0h busy=%0b exp sel=3 busy=1", bus.sel, bus.busy);
    end
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL t5_rdy got=%0h exp=0", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_nobeat got v=%0b busy=%0b exp v=0 busy=0", bus.out_valid, bus.busy);
    end
    tick();
    checks++;
    if (bus.sel !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_next got sel=%0h busy=%0b exp sel=0 busy=1", bus.sel, bus.busy);
    end
  endtask

  task automatic test_lone();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      setd(2, 32'h200 + 32'(k));
      tick();
      checks++;
      if (bus.sel !== 2'd2 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL t6_grant%0d got sel=%0h busy=%0b rdy=%0h exp sel=2 busy=1 rdy=4", k,
                 bus.sel, bus.busy, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.sel !== 2'd2 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 ||
          bus.out_valid !== 1'b1 || bus.out_data !== 32'h200 + 32'(k)) begin
        errors++;
        $display("FAIL t6_beat%0d got sel=%0h busy=%0b rdy=%0h v=%0b d=%0h exp d=%0h", k,
                 bus.sel, bus.busy, bus.req_ready, bus.out_valid, bus.out_data, 32'h200 + 32'(k));
      end
    end
  endtask

  // BURST_MAX=1 instance: lock must not extend a grant.
  task automatic test_burst_max1();
    do_reset();
    bus1.req_valid = 4'b0011;
    bus1.req_lock  = 4'b0011;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus1.sel !== 2'(k % 2) || bus1.busy !== 1'b1) begin
        errors++;
        $display("FAIL b1_grant%0d got sel=%0h busy=%0b exp sel=%0h busy=1", k,
                 bus1.sel, bus1.busy, k % 2);
      end
      tick();
      checks++;
      if (bus1.busy !== 1'b0 || bus1.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b1_end%0d got busy=%0b v=%0b exp busy=0 v=1", k, bus1.busy, bus1.out_valid);
      end
    end
  endtask

  // Random traffic checked against a grant-level reference model and an
  // in-order scoreboard of accepted words.
  task automatic test_random();
    logic [1:0]  ptr_m, g;
    bit          ing, ov_m, free, found;
    int          b;
    logic [3:0]  v, exp_rdy;
    logic [31:0] q[$];
    logic [31:0] dd;
    do_reset();
    ptr_m = 2'd3; ing = 1'b0; ov_m = 1'b0; b = 0; g = 2'd0;
    for (int n = 0; n < 600; n++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.req_lock  = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) setd(i, $urandom);
      @(negedge clk);
      v = bus.req_valid;
      checks++;
      if (bus.out_valid !== ov_m) begin
        errors++;
        $display("FAIL rnd_ov cyc%0d got=%0b exp=%0b", n, bus.out_valid, ov_m);
      end
      if (ov_m && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_sb cyc%0d got=%0h exp=<none>", n, bus.out_data);
        end else begin
          dd = q.pop_front();
          if (bus.out_data !== dd) begin
            errors++;
            $display("FAIL rnd_data cyc%0d got=%0h exp=%0h", n, bus.out_data, dd);
          end
        end
      end
      free = !ov_m || bus.out_ready;
      if (!ing) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL rnd_idle cyc%0d got busy=%0b rdy=%0h exp 0 0", n, bus.busy, bus.req_ready);
        end
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && v[(int'(ptr_m) + k) % 4]) begin
            g = 2'((int'(ptr_m) + k) % 4);
            found = 1'b1;
          end
        end
        if (found) begin
          ing = 1'b1;
          b = 0;
        end
        if (free && ov_m && bus.out_ready) ov_m = 1'b0;
      end else begin
        exp_rdy = (v[g] && free) ? (4'b0001 << g) : 4'b0000;
        checks++;
        if (bus.busy !== 1'b1 || bus.sel !== g || bus.req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL rnd_xfer cyc%0d got busy=%0b sel=%0h rdy=%0h exp busy=1 sel=%0h rdy=%0h",
                   n, bus.busy, bus.sel, bus.req_ready, g, exp_rdy);
        end
        if (!v[g]) begin
          ing = 1'b0;
          ptr_m = g;
          if (ov_m && bus.out_ready) ov_m = 1'b0;
        end else if (free) begin
          q.push_back(bus.req_data[int'(g)*32 +: 32]);
          ov_m = 1'b1;
          b++;
          if (!(bus.req_lock[g] && b < 4)) begin
            ing = 1'b0;
            ptr_m = g;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_withdraw();
    test_lone();
    test_burst_max1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
